input_bank_ctrl: RTL and testbench

Sequencing controller for the memory-mapped input bank (switches, buttons, button-event flags) at 0x0000_7000–0x0000_7FFF. It accepts LSU load/store requests, synchronizes the external inputs, and runs each access through a fixed-latency FSM. It extracts byte and halfword fields per funct3 with sign or zero extension and returns data with a one-cycle acknowledge. It also owns the sticky button-event flag register: set on button rising edges, cleared by write-1-to-clear.

---
 rtl/input_bank_ctrl.sv | 170 +++++++++++++++++
 tb/tb_input_bank_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_bank_ctrl.sv
// Memory-mapped input bank controller: synchronizes switches and buttons, serves LSU loads/stores
// through a fixed IDLE/BUSY/RESP sequence and keeps sticky W1C button-event flags.
module input_bank_ctrl #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_io_sw,
   input  logic [3:0]  i_io_btn,
   input  logic [31:0] i_lsu_addr,
   input  logic        i_lsu_rden,
   input  logic        i_lsu_wren,
   input  logic [31:0] i_lsu_wdata,
   input  logic [2:0]  i_funct3,
   output logic        o_lsu_ack,
   output logic [31:0] o_rdata,
   output logic        o_lsu_err,
   output logic [3:0]  o_btn_flag,
   output logic        o_irq
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]  state_q;
   logic [11:0] addr_q;
   logic [2:0]  funct3_q;
   logic [3:0]  wdata_q;
   logic        is_read_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] sw_sync_q  [SYNC_STAGES];
   logic [3:0]  btn_sync_q [SYNC_STAGES];
   logic [3:0]  prev_btn_q;
   logic [3:0]  flag_q;
   logic [3:0]  flag_d;

   logic [31:0] sw_sync;
   logic [3:0]  btn_sync;
   logic        req;
   logic [31:0] word;
   logic [31:0] shifted;
   logic [15:0] half;
   logic [31:0] res_data;
   logic        res_err;
   logic [3:0]  flag_set;
   logic [3:0]  flag_clr;

   // Only the flag bits of the store data are meaningful.
   logic unused_wdata;
   assign unused_wdata = ^i_lsu_wdata[31:4];

   assign sw_sync  = sw_sync_q[SYNC_STAGES-1];
   assign btn_sync = btn_sync_q[SYNC_STAGES-1];
   assign req      = (i_lsu_rden | i_lsu_wren) && (i_lsu_addr[31:12] == 20'h00007);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sw_sync_q[i]  <= '0;
            btn_sync_q[i] <= '0;
         end
      end else begin
         sw_sync_q[0]  <= i_io_sw;
         btn_sync_q[0] <= i_io_btn;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sw_sync_q[i]  <= sw_sync_q[i-1];
            btn_sync_q[i] <= btn_sync_q[i-1];
         end
      end
   end

   always_comb begin
      word = '0;
      if (addr_q[11:4] == 8'h00) begin
         word = sw_sync;
      end else if (addr_q[11:4] == 8'h01) begin
         word = {28'b0, btn_sync};
      end else if (addr_q[11:4] == 8'h80) begin
         word = {28'b0, flag_q};
      end
      shifted  = word >> {addr_q[1:0], 3'b000};
      half     = addr_q[1] ? word[31:16] : word[15:0];
      res_data = '0;
      res_err  = 1'b0;
      if (is_read_q) begin
         case (funct3_q)
            3'b000: res_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100: res_data = {24'b0, shifted[7:0]};
            3'b001: begin
               if (addr_q[0]) res_err = 1'b1;
               else res_data = {{16{half[15]}}, half};
            end
            3'b101: begin
               if (addr_q[0]) res_err = 1'b1;
               else res_data = {16'b0, half};
            end
            3'b010: begin
               if (addr_q[1:0] != 2'b00) res_err = 1'b1;
               else res_data = word;
            end
            default: res_err = 1'b1;
         endcase
      end
   end

   // Set beats a same-cycle W1C clear so no button event is lost.
   always_comb begin
      flag_set = btn_sync & ~prev_btn_q;
      flag_clr = '0;
      if (state_q == StBusy && !is_read_q && addr_q[11:4] == 8'h80) begin
         flag_clr = wdata_q;
      end
      flag_d = (flag_q & ~flag_clr) | flag_set;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev_btn_q <= '0;
         flag_q     <= '0;
      end else begin
         prev_btn_q <= btn_sync;
         flag_q     <= flag_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         funct3_q  <= '0;
         wdata_q   <= '0;
         is_read_q <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req) begin
                  addr_q    <= i_lsu_addr[11:0];
                  funct3_q  <= i_funct3;
                  wdata_q   <= i_lsu_wdata[3:0];
                  is_read_q <= i_lsu_rden;
                  state_q   <= StBusy;
               end
            end
            StBusy: begin
               rdata_q <= res_data;
               err_q   <= res_err;
               state_q <= StResp;
            end
            StResp: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_lsu_ack  = (state_q == StResp);
   assign o_rdata    = rdata_q;
   assign o_lsu_err  = err_q;
   assign o_btn_flag = flag_q;
   assign o_irq      = |flag_q;

endmodule

// File: tb/tb_input_bank_ctrl.sv
// Directed self-checking bench for input_bank_ctrl; each task covers one feature.
module tb_input_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sw;
   logic [3:0]  btn;
   logic [31:0] addr;
   logic        rden;
   logic        wren;
   logic [31:0] wdata;
   logic [2:0]  funct3;
   logic        ack;
   logic [31:0] rdata;
   logic        err;
   logic [3:0]  flag;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   input_bank_ctrl #(
      .SYNC_STAGES(2)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_io_sw    (sw),
      .i_io_btn   (btn),
      .i_lsu_addr (addr),
      .i_lsu_rden (rden),
      .i_lsu_wren (wren),
      .i_lsu_wdata(wdata),
      .i_funct3   (funct3),
      .o_lsu_ack  (ack),
      .o_rdata    (rdata),
      .o_lsu_err  (err),
      .o_btn_flag (flag),
      .o_irq      (irq)
   );

   // Issues one request at a negedge and collects the response; returns at a negedge.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] wd, output int lat,
                         output logic [31:0] rd_obs, output logic err_obs,
                         output logic extra_ack);
      rden = rd; wren = wr; addr = a; funct3 = f3; wdata = wd;
      lat = -1; rd_obs = '0; err_obs = 1'b0;
      for (int i = 1; i <= 8 && lat < 0; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            lat = i; rd_obs = rdata; err_obs = err;
         end
      end
      rden = 1'b0; wren = 1'b0;
      @(posedge clk); #1;
      extra_ack = ack;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; sw = 32'hA332_2110; btn = 4'h0;
      rden = 1'b0; wren = 1'b0; addr = '0; wdata = '0; funct3 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ack, rdata, err, flag, irq} !== 38'd0) begin
         failures++;
         $display("FAIL reset_outputs got ack=%b rdata=%h err=%b flag=%h irq=%b want all 0",
                  ack, rdata, err, flag, irq);
      end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_word_read();
      int lat; logic [31:0] r; logic e; logic x;
      access(1'b1, 1'b0, 32'h0000_7000, 3'b010, 32'h0, lat, r, e, x);
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL lw_latency got %0d want 2", lat);
      end
      checks++;
      if (r !== 32'hA332_2110 || e !== 1'b0) begin
         failures++; $display("FAIL lw_data got %h err=%b want a3322110 err=0", r, e);
      end
      checks++;
      if (x !== 1'b0) begin
         failures++; $display("FAIL lw_single_ack got ack=%b after response want 0", x);
      end
   endtask

   task automatic test_byte_half();
      logic [31:0] a_tab [7] = '{32'h7003, 32'h7003, 32'h7002, 32'h7000, 32'h7001,
                                 32'h7000, 32'h7002};
      logic [2:0]  f_tab [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b101};
      logic [31:0] e_tab [7] = '{32'hFFFF_FFA3, 32'h0000_00A3, 32'hFFFF_A332, 32'h0000_2110,
                                 32'h0000_0021, 32'h0000_2110, 32'h0000_A332};
      int lat; logic [31:0] r; logic e; logic x;
      for (int i = 0; i < 7; i++) begin
         access(1'b1, 1'b0, a_tab[i], f_tab[i], 32'h0, lat, r, e, x);
         checks++;
         if (lat !== 2 || r !== e_tab[i] || e !== 1'b0) begin
            failures++;
            $display("FAIL subword_%0d got lat=%0d rdata=%h err=%b want lat=2 rdata=%h err=0",
                     i, lat, r, e, e_tab[i]);
         end
      end
   endtask

   task automatic test_flags();
      int lat; logic [31:0] r; logic e; logic x;
      btn = 4'h9;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (flag !== (i == 3 ? 4'h9 : 4'h0) || irq !== (i == 3)) begin
            failures++;
            $display("FAIL flag_latency_%0d got flag=%h irq=%b want %h", i, flag, irq,
                     (i == 3 ? 4'h9 : 4'h0));
         end
      end
      @(negedge clk);
      access(1'b1, 1'b0, 32'h7010, 3'b010, 32'h0, lat, r, e, x);
      checks++;
      if (r !== 32'h9 || e !== 1'b0) begin
         failures++; $display("FAIL btn_read got %h err=%b want 00000009 err=0", r, e);
      end
      access(1'b0, 1'b1, 32'h7800, 3'b010, 32'h1, lat, r, e, x);
      checks++;
      if (lat !== 2 || r !== 32'h0 || e !== 1'b0 || flag !== 4'h8) begin
         failures++;
         $display("FAIL w1c_bit0 got lat=%0d rdata=%h err=%b flag=%h want 2 0 0 8",
                  lat, r, e, flag);
      end
      access(1'b1, 1'b0, 32'h7800, 3'b010, 32'h0, lat, r, e, x);
      checks++;
      if (r !== 32'h8 || e !== 1'b0) begin
         failures++; $display("FAIL flag_read got %h err=%b want 00000008 err=0", r, e);
      end
      access(1'b0, 1'b1, 32'h7800, 3'b010, 32'h8, lat, r, e, x);
      checks++;
      if (flag !== 4'h0 || irq !== 1'b0) begin
         failures++; $display("FAIL w1c_bit3 got flag=%h irq=%b want 0 0", flag, irq);
      end
   endtask

   task automatic test_errors();
      logic [31:0] a_tab [5] = '{32'h7802, 32'h7011, 32'h7000, 32'h7400, 32'h7004};
      logic [2:0]  f_tab [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b110};
      logic        e_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      int lat; logic [31:0] r; logic e; logic x;
      for (int i = 0; i < 5; i++) begin
         access(1'b1, 1'b0, a_tab[i], f_tab[i], 32'h0, lat, r, e, x);
         checks++;
         if (lat !== 2 || r !== 32'h0 || e !== e_tab[i]) begin
            failures++;
            $display("FAIL err_case_%0d got lat=%0d rdata=%h err=%b want lat=2 rdata=0 err=%b",
                     i, lat, r, e, e_tab[i]);
         end
      end
   endtask

   task automatic test_collisions();
      int lat; logic [31:0] r; logic e; logic x;
      btn = 4'h0;
      repeat (4) @(negedge clk);
      btn = 4'h1;
      @(negedge clk);
      access(1'b0, 1'b1, 32'h7800, 3'b010, 32'h1, lat, r, e, x);
      checks++;
      if (flag !== 4'h1) begin
         failures++; $display("FAIL set_vs_clear got flag=%h want 1", flag);
      end
      access(1'b1, 1'b1, 32'h7800, 3'b010, 32'hF, lat, r, e, x);
      checks++;
      if (r !== 32'h1 || e !== 1'b0 || flag !== 4'h1) begin
         failures++;
         $display("FAIL rd_wr_both got rdata=%h err=%b flag=%h want 1 0 1", r, e, flag);
      end
   endtask

   task automatic test_reset_abort();
      int lat; logic [31:0] r; logic e; logic x;
      rden = 1'b1; addr = 32'h7000; funct3 = 3'b010;
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({ack, rdata, err, flag, irq} !== 38'd0) begin
         failures++;
         $display("FAIL reset_abort got ack=%b rdata=%h err=%b flag=%h irq=%b want all 0",
                  ack, rdata, err, flag, irq);
      end
      rden = 1'b0;
      @(negedge clk); rst = 1'b0;
      x = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         x = x | ack;
      end
      checks++;
      if (x !== 1'b0) begin
         failures++; $display("FAIL abort_no_ack got ack=1 after reset want 0");
      end
      @(negedge clk);
      access(1'b1, 1'b0, 32'h7000, 3'b010, 32'h0, lat, r, e, x);
      checks++;
      if (lat !== 2 || r !== 32'hA332_2110 || e !== 1'b0) begin
         failures++;
         $display("FAIL reissue got lat=%0d rdata=%h err=%b want 2 a3322110 0", lat, r, e);
      end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_byte_half();
      test_flags();
      test_errors();
      test_collisions();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
